// File: rtl/radix4_otf_divider.sv
// Radix-4 SRT-style unsigned divider with on-the-fly quotient conversion.
// Produces Q = floor(X*4^(k-1)/D) and the matching non-negative remainder.
// The block emits one signed digit in {-2..+2} per cycle, then applies a
// single final correction step.

module radix4_otf_divider #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 12,
  localparam int KW    = $clog2(DIGITS + 1),
  localparam int QW    = 2 * DIGITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [KW-1:0]    num_digits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             err
);

  // The residual stays within +/-(8/3)D < 2^(WIDTH+2), so 2r also fits in
  // WIDTH+4 signed bits. All digit-selection arithmetic runs at this width.
  localparam int RW = WIDTH + 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [KW-1:0] DIGITS_K = KW'(DIGITS);

  // Signed digit encoding, two's complement in 3 bits
  localparam logic [2:0] Q_P2 = 3'b010;
  localparam logic [2:0] Q_P1 = 3'b001;
  localparam logic [2:0] Q_Z0 = 3'b000;
  localparam logic [2:0] Q_M1 = 3'b111;
  localparam logic [2:0] Q_M2 = 3'b110;

  logic [1:0]           state_reg;
  logic [WIDTH-1:0]     d_reg;
  logic [KW-1:0]        k_reg;
  logic [KW-1:0]        cnt_reg;
  logic signed [RW-1:0] r_reg;
  logic [QW-1:0]        a_reg;
  logic [QW-1:0]        b_reg;
  logic [WIDTH-1:0]     s_low_reg;
  logic                 s_neg_reg;
  logic [QW-1:0]        quotient_reg;
  logic [WIDTH-1:0]     remainder_reg;
  logic                 err_reg;

  logic                 accept;
  logic                 bad_operands;
  logic                 last_digit;
  logic signed [RW-1:0] d_ext;
  logic signed [RW-1:0] three_d;
  logic signed [RW-1:0] two_r;
  logic signed [RW-1:0] qd;
  logic signed [RW-1:0] s_next;
  logic signed [RW-1:0] r_next;
  logic [2:0]           q_digit;
  logic [QW-1:0]        a_next;
  logic [QW-1:0]        b_next;

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign err       = err_reg;

  assign accept = in_valid && in_ready;

  // Operands the iteration cannot handle: zero divisor, X beyond the
  // convergence bound 2D, or a digit count outside 1..DIGITS.
  always_comb begin
    bad_operands = 1'b0;
    if (divisor == '0) begin
      bad_operands = 1'b1;
    end
    if ({1'b0, dividend} > {divisor, 1'b0}) begin
      bad_operands = 1'b1;
    end
    if ((num_digits == '0) || (num_digits > DIGITS_K)) begin
      bad_operands = 1'b1;
    end
  end

  assign last_digit = (cnt_reg == (k_reg - KW'(1)));

  // Digit selection by exact comparison of 2r against the +/-D, +/-3D
  // thresholds, followed by the partial remainder s = r - q*D.
  always_comb begin
    d_ext   = signed'({4'b0000, d_reg});
    three_d = d_ext + (d_ext <<< 1);
    two_r   = r_reg <<< 1;
    q_digit = Q_M2;
    qd      = -(d_ext <<< 1);
    if (two_r >= three_d) begin
      q_digit = Q_P2;
      qd      = d_ext <<< 1;
    end else if (two_r >= d_ext) begin
      q_digit = Q_P1;
      qd      = d_ext;
    end else if (two_r >= -d_ext) begin
      q_digit = Q_Z0;
      qd      = '0;
    end else if (two_r >= -three_d) begin
      q_digit = Q_M1;
      qd      = -d_ext;
    end
    s_next = r_reg - qd;
    r_next = s_next <<< 2;
  end

  // On-the-fly conversion: A holds the quotient so far, B holds A-1, so a
  // negative digit never needs a carry-propagating subtraction.
  always_comb begin
    a_next = {a_reg[QW-3:0], 2'd0};
    b_next = {b_reg[QW-3:0], 2'd3};
    case (q_digit)
      Q_P2: begin
        a_next = {a_reg[QW-3:0], 2'd2};
        b_next = {a_reg[QW-3:0], 2'd1};
      end
      Q_P1: begin
        a_next = {a_reg[QW-3:0], 2'd1};
        b_next = {a_reg[QW-3:0], 2'd0};
      end
      Q_M1: begin
        a_next = {b_reg[QW-3:0], 2'd3};
        b_next = {b_reg[QW-3:0], 2'd2};
      end
      Q_M2: begin
        a_next = {b_reg[QW-3:0], 2'd2};
        b_next = {b_reg[QW-3:0], 2'd1};
      end
      default: begin
        a_next = {a_reg[QW-3:0], 2'd0};
        b_next = {b_reg[QW-3:0], 2'd3};
      end
    endcase
  end

  // Control FSM plus datapath registers: accept, iterate, correct, hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      d_reg         <= '0;
      k_reg         <= '0;
      cnt_reg       <= '0;
      r_reg         <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      s_low_reg     <= '0;
      s_neg_reg     <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            d_reg <= divisor;
            k_reg <= num_digits;
            if (bad_operands) begin
              quotient_reg  <= '1;
              remainder_reg <= '0;
              err_reg       <= 1'b1;
              state_reg     <= DONE;
            end else begin
              r_reg     <= signed'({4'b0000, dividend});
              a_reg     <= '0;
              b_reg     <= '0;
              cnt_reg   <= '0;
              err_reg   <= 1'b0;
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          a_reg   <= a_next;
          b_reg   <= b_next;
          cnt_reg <= cnt_reg + KW'(1);
          if (last_digit) begin
            // The final digit's partial remainder is kept unscaled for FIX.
            // Only its sign and low WIDTH bits matter: the corrected
            // remainder lies in [0, D) and wraps correctly modulo 2^WIDTH.
            s_low_reg <= s_next[WIDTH-1:0];
            s_neg_reg <= s_next[RW-1];
            state_reg <= FIX;
          end else begin
            r_reg <= r_next;
          end
        end
        FIX: begin
          if (s_neg_reg) begin
            quotient_reg  <= b_reg;
            remainder_reg <= s_low_reg + d_reg;
          end else begin
            quotient_reg  <= a_reg;
            remainder_reg <= s_low_reg;
          end
          state_reg <= DONE;
        end
        default: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_radix4_otf_divider.sv
// Directed and randomized checks for radix4_otf_divider (WIDTH=20, DIGITS=12).
module tb_radix4_otf_divider;

  localparam int W  = 20;
  localparam int N  = 12;
  localparam int KW = 4;
  localparam int QW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic [KW-1:0] num_digits;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] quotient;
  logic [W-1:0]  remainder;
  logic          err;

  int tests = 0;
  int fails = 0;

  radix4_otf_divider #(.WIDTH(W), .DIGITS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .num_digits (num_digits),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one operation, wait for the handshake and then for out_valid.
  // lat counts clock edges from the acceptance edge to the first edge at
  // which out_valid is seen high.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] d,
                        input logic [KW-1:0] k, output int lat,
                        output logic [QW-1:0] q, output logic [W-1:0] rm,
                        output logic e);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    dividend   = x;
    divisor    = d;
    num_digits = k;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q  = quotient;
    rm = remainder;
    e  = err;
  endtask

  // Accept the result and let the block return to IDLE.
  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Directed vector with hand-computed expectations.
  task automatic directed(input string tag, input logic [W-1:0] x, input logic [W-1:0] d,
                          input logic [KW-1:0] k, input logic [QW-1:0] exp_q,
                          input logic [W-1:0] exp_r, input logic exp_e, input int exp_lat);
    int lat;
    logic [QW-1:0] q;
    logic [W-1:0] rm;
    logic e;
    run_op(x, d, k, lat, q, rm, e);
    $display("[TB] op %s: X=%0d D=%0d k=%0d -> Q=%0d R=%0d err=%0d lat=%0d",
             tag, x, d, k, q, rm, e, lat);
    chk({tag, " quotient"}, 64'(q), 64'(exp_q));
    chk({tag, " remainder"}, 64'(rm), 64'(exp_r));
    chk({tag, " err"}, 64'(e), 64'(exp_e));
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    release_result();
    chk({tag, " idle after release"}, 64'({in_ready, out_valid}), 64'(2'b10));
  endtask

  initial begin
    int lat;
    logic [QW-1:0] q;
    logic [QW-1:0] q_hold;
    logic [W-1:0] rm;
    logic [W-1:0] rm_hold;
    logic e;
    logic spurious;
    longint unsigned num;
    longint unsigned dd;
    longint unsigned xx;
    int rnd_bad;

    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    dividend   = '0;
    divisor    = '0;
    num_digits = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset quotient", 64'(quotient), 64'd0);
    chk("reset remainder", 64'(remainder), 64'd0);
    chk("reset err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Hand-computed vectors: Q = floor(X*4^(k-1)/D)
    directed("x1d3k2", 20'd1, 20'd3, 4'd2, 24'd1, 20'd1, 1'b0, 4);
    directed("x2d3k2", 20'd2, 20'd3, 4'd2, 24'd2, 20'd2, 1'b0, 4);
    directed("x5d3k1", 20'd5, 20'd3, 4'd1, 24'd1, 20'd2, 1'b0, 3);
    directed("x6d3k1", 20'd6, 20'd3, 4'd1, 24'd2, 20'd0, 1'b0, 3);
    directed("x13d7k3", 20'd13, 20'd7, 4'd3, 24'd29, 20'd5, 1'b0, 5);
    directed("x0d5k4", 20'd0, 20'd5, 4'd4, 24'd0, 20'd0, 1'b0, 6);
    directed("x2d1k12", 20'd2, 20'd1, 4'd12, 24'd8388608, 20'd0, 1'b0, 14);
    directed("x2dmaxk12", 20'd1048574, 20'd524287, 4'd12, 24'd8388608, 20'd0, 1'b0, 14);
    directed("xdmaxk12", 20'd1048575, 20'd1048575, 4'd12, 24'd4194304, 20'd0, 1'b0, 14);
    directed("x1dmaxk12", 20'd1, 20'd1048575, 4'd12, 24'd4, 20'd4, 1'b0, 14);
    // Error cases: quotient all ones, remainder 0, one-cycle latency
    directed("err x7d3", 20'd7, 20'd3, 4'd1, 24'hFFFFFF, 20'd0, 1'b1, 1);
    directed("err d0", 20'd0, 20'd0, 4'd3, 24'hFFFFFF, 20'd0, 1'b1, 1);
    directed("err k0", 20'd1, 20'd3, 4'd0, 24'hFFFFFF, 20'd0, 1'b1, 1);
    directed("err k13", 20'd1, 20'd3, 4'd13, 24'hFFFFFF, 20'd0, 1'b1, 1);

    // Backpressure: result held for 5 cycles, new request ignored
    run_op(20'd13, 20'd7, 4'd3, lat, q_hold, rm_hold, e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dividend   = 20'd1;
      divisor    = 20'd3;
      num_digits = 4'd2;
      in_valid   = 1'b1;
      @(posedge clk);
      #1;
      $display("[TB] hold cycle %0d: Q=%0d R=%0d out_valid=%0d in_ready=%0d",
               i, quotient, remainder, out_valid, in_ready);
      chk("hold quotient", 64'(quotient), 64'd29);
      chk("hold remainder", 64'(remainder), 64'd5);
      chk("hold flags", 64'({out_valid, in_ready, err}), 64'(3'b100));
    end
    in_valid = 1'b0;
    release_result();
    chk("hold release idle", 64'({in_ready, out_valid}), 64'(2'b10));
    directed("after hold", 20'd2, 20'd3, 4'd2, 24'd2, 20'd2, 1'b0, 4);

    // Reset in the middle of a long operation aborts it
    @(negedge clk);
    dividend   = 20'd5;
    divisor    = 20'd9;
    num_digits = 4'd12;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] reset mid-run: in_ready=%0d out_valid=%0d", in_ready, out_valid);
    chk("midrun reset idle", 64'({in_ready, out_valid}), 64'(2'b10));
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) spurious = 1'b1;
    end
    chk("midrun no out_valid", 64'(spurious), 64'd0);

    // Randomized full-length operations against a 64-bit reference
    rnd_bad = 0;
    for (int n = 0; n < 300; n++) begin
      dd  = longint'($urandom_range(1, 1048575));
      xx  = longint'($urandom_range(0, 32'(dd < 64'd524288 ? 2 * dd : 64'd1048575)));
      num = xx << 22;
      run_op(W'(xx), W'(dd), 4'd12, lat, q, rm, e);
      $display("[TB] rnd %0d: X=%0d D=%0d -> Q=%0d R=%0d", n, xx, dd, q, rm);
      chk("rnd quotient", 64'(q), num / dd);
      chk("rnd remainder", 64'(rm), num % dd);
      chk("rnd err", 64'(e), 64'd0);
      chk("rnd latency", 64'(lat), 64'd14);
      release_result();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
